// File: rtl/ss_smooth_signed_multi_if.sv
// Channel bus for the signed stochastic smoother: shared control plus per-channel
// magnitude/sign inputs and registered smoothed outputs.
interface ss_smooth_signed_multi_if #(
    parameter int NCH = 4
);
    logic           EN;
    logic           MODE;
    logic [NCH-1:0] IN;
    logic [NCH-1:0] SIGN;
    logic [NCH-1:0] OUT;
    logic [NCH-1:0] OUT_SIGN;
    logic [NCH-1:0] SAT;

    modport master (
        output EN, MODE, IN, SIGN,
        input  OUT, OUT_SIGN, SAT
    );

    modport slave (
        input  EN, MODE, IN, SIGN,
        output OUT, OUT_SIGN, SAT
    );
endinterface

// File: rtl/ss_smooth_signed_multi.sv
// Multi-channel smoother for signed stochastic streams: run-length window detect
// (MODE=0) or leaky saturating up/down accumulator with magnitude threshold (MODE=1).
//
// state  | meaning
// ST_RUN | run-length mode, RUNP/RUNN count consecutive same-sign ones
// ST_ACC | accumulator mode, ACC integrates +1/-1 steps with optional leak
module ss_smooth_signed_multi #(
    parameter int NCH = 4,
    parameter int NS  = 4,
    parameter int CW  = 6,
    parameter int TH  = 8,
    parameter int LK  = 0
) (
    input logic                     CLK,
    input logic                     INIT,
    ss_smooth_signed_multi_if.slave bus
);
    localparam int RW = $clog2(NS + 1);
    localparam int PW = (LK > 0) ? LK : 1;
    localparam logic [RW-1:0]        NSV     = RW'(NS);
    localparam logic signed [CW:0]   ONE     = (CW+1)'(1);
    localparam logic signed [CW:0]   ACC_MAX = (CW+1)'((1 << (CW-1)) - 1);
    localparam logic signed [CW:0]   ACC_MIN = -ACC_MAX;
    localparam logic signed [CW:0]   THV     = (CW+1)'(TH);

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_ACC = 1'b1
    } mode_t;

    mode_t mode_q, mode_d;
    logic  mode_chg;

    logic [NCH-1:0][RW-1:0] runp_q, runp_d, runn_q, runn_d;
    logic [NCH-1:0][CW-1:0] acc_q, acc_d;
    logic [NCH-1:0]         out_q, out_d, osgn_q, osgn_d, sat_q, sat_d;
    logic [PW-1:0]          pre_q, pre_d;
    logic                   leak_tick;

    logic                   p, n;
    logic signed [CW:0]     acc_cur, step, leak, sum, mag;

    always_ff @(posedge CLK) begin
        if (INIT) mode_q <= mode_t'(bus.MODE);
        else      mode_q <= mode_d;
    end

    always_comb begin
        mode_d   = mode_q;
        mode_chg = 1'b0;
        if (bus.EN) begin
            mode_d   = mode_t'(bus.MODE);
            mode_chg = (mode_t'(bus.MODE) != mode_q);
        end
    end

    always_comb begin
        runp_d    = runp_q;
        runn_d    = runn_q;
        acc_d     = acc_q;
        out_d     = out_q;
        osgn_d    = osgn_q;
        sat_d     = sat_q;
        pre_d     = pre_q;
        p         = 1'b0;
        n         = 1'b0;
        acc_cur   = '0;
        step      = '0;
        leak      = '0;
        sum       = '0;
        mag       = '0;
        // prescaler sits at all-ones on the cycle that applies the leak
        leak_tick = (LK > 0) && (pre_q == {PW{1'b1}});

        if (mode_chg) begin
            runp_d = '0;
            runn_d = '0;
            acc_d  = '0;
            out_d  = '0;
            osgn_d = '0;
            sat_d  = '0;
            pre_d  = '0;
        end else if (bus.EN) begin
            pre_d = (LK > 0) ? pre_q + PW'(1) : '0;
            for (int c = 0; c < NCH; c++) begin
                p = bus.IN[c] & ~bus.SIGN[c];
                n = bus.IN[c] &  bus.SIGN[c];
                if (mode_q == ST_RUN) begin
                    runp_d[c] = p ? ((runp_q[c] == NSV) ? NSV : runp_q[c] + RW'(1)) : '0;
                    runn_d[c] = n ? ((runn_q[c] == NSV) ? NSV : runn_q[c] + RW'(1)) : '0;
                    out_d[c]  = (runp_q[c] == NSV) | (runn_q[c] == NSV);
                    osgn_d[c] = (runn_q[c] == NSV);
                    sat_d[c]  = 1'b0;
                end else begin
                    runp_d[c] = '0;
                    runn_d[c] = '0;
                    acc_cur   = {acc_q[c][CW-1], acc_q[c]};
                    step      = p ? ONE : (n ? -ONE : '0);
                    if (leak_tick && acc_cur > 0)      leak = -ONE;
                    else if (leak_tick && acc_cur < 0) leak = ONE;
                    else                               leak = '0;
                    // one extra bit of headroom so the clamp sees the true sum
                    sum = acc_cur + step + leak;
                    if (sum > ACC_MAX)      sum = ACC_MAX;
                    else if (sum < ACC_MIN) sum = ACC_MIN;
                    acc_d[c]  = sum[CW-1:0];
                    mag       = acc_cur[CW] ? -acc_cur : acc_cur;
                    out_d[c]  = (mag >= THV);
                    osgn_d[c] = acc_cur[CW];
                    sat_d[c]  = (mag == ACC_MAX);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (INIT) begin
            runp_q <= '0;
            runn_q <= '0;
            acc_q  <= '0;
            out_q  <= '0;
            osgn_q <= '0;
            sat_q  <= '0;
            pre_q  <= '0;
        end else begin
            runp_q <= runp_d;
            runn_q <= runn_d;
            acc_q  <= acc_d;
            out_q  <= out_d;
            osgn_q <= osgn_d;
            sat_q  <= sat_d;
            pre_q  <= pre_d;
        end
    end

    assign bus.OUT      = out_q;
    assign bus.OUT_SIGN = osgn_q;
    assign bus.SAT      = sat_q;
endmodule

// File: tb/tb_ss_smooth_signed_multi.sv
// Directed bench for ss_smooth_signed_multi: run-length and accumulator modes,
// leak, enable freeze, reset and mode-switch clearing.
module tb_ss_smooth_signed_multi;
    logic CLK = 1'b0;
    logic INIT0, INIT1;
    int   nvec = 0;
    int   nerr = 0;

    always #5 CLK = ~CLK;

    ss_smooth_signed_multi_if #(.NCH(4)) bus0 ();
    ss_smooth_signed_multi_if #(.NCH(4)) bus1 ();

    ss_smooth_signed_multi #(.NCH(4), .NS(4), .CW(6), .TH(8), .LK(0)) u_dut0 (
        .CLK  (CLK),
        .INIT (INIT0),
        .bus  (bus0.slave)
    );

    // leak instance: low threshold so the slow decay is visible on OUT
    ss_smooth_signed_multi #(.NCH(4), .NS(4), .CW(6), .TH(3), .LK(3)) u_dut1 (
        .CLK  (CLK),
        .INIT (INIT1),
        .bus  (bus1.slave)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        INIT0 = 1'b1; INIT1 = 1'b1;
        bus0.EN = 1'b1; bus0.MODE = 1'b0; bus0.IN = '0; bus0.SIGN = '0;
        bus1.EN = 1'b1; bus1.MODE = 1'b1; bus1.IN = '0; bus1.SIGN = '0;
        tick(); tick();
        INIT0 = 1'b0;
        nvec++; if (bus0.OUT !== 4'b0000) begin nerr++; $display("FAIL reset_out: got %b want 0000", bus0.OUT); end
        nvec++; if (bus0.OUT_SIGN !== 4'b0000) begin nerr++; $display("FAIL reset_osgn: got %b want 0000", bus0.OUT_SIGN); end
        nvec++; if (bus0.SAT !== 4'b0000) begin nerr++; $display("FAIL reset_sat: got %b want 0000", bus0.SAT); end
        nvec++; if (bus1.OUT !== 4'b0000) begin nerr++; $display("FAIL reset_out_lk: got %b want 0000", bus1.OUT); end
    endtask

    task automatic test_run_pos();
        bus0.IN = 4'b0001; bus0.SIGN = 4'b0000;
        for (int i = 1; i <= 4; i++) tick();
        nvec++; if (bus0.OUT !== 4'b0000) begin nerr++; $display("FAIL t1_out_e4: got %b want 0000", bus0.OUT); end
        tick();
        nvec++; if (bus0.OUT !== 4'b0001) begin nerr++; $display("FAIL t1_out_e5: got %b want 0001", bus0.OUT); end
        nvec++; if (bus0.OUT_SIGN !== 4'b0000) begin nerr++; $display("FAIL t1_osgn_e5: got %b want 0000", bus0.OUT_SIGN); end
        bus0.IN = 4'b0000;
        tick();
        nvec++; if (bus0.OUT !== 4'b0001) begin nerr++; $display("FAIL t1_out_e6: got %b want 0001", bus0.OUT); end
        tick();
        nvec++; if (bus0.OUT !== 4'b0000) begin nerr++; $display("FAIL t1_out_e7: got %b want 0000", bus0.OUT); end
        // run one short of NS must never assert
        bus0.IN = 4'b0001;
        for (int i = 0; i < 3; i++) tick();
        bus0.IN = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            nvec++; if (bus0.OUT !== 4'b0000) begin nerr++; $display("FAIL t1_short_run %0d: got %b want 0000", i, bus0.OUT); end
        end
    endtask

    task automatic test_run_alt();
        for (int i = 0; i < 20; i++) begin
            bus0.IN = 4'b0010;
            bus0.SIGN = (i % 2 == 0) ? 4'b0010 : 4'b0000;
            tick();
            nvec++; if (bus0.OUT !== 4'b0000) begin nerr++; $display("FAIL t2_alt %0d: got %b want 0000", i, bus0.OUT); end
        end
        bus0.SIGN = 4'b0010;
        for (int i = 0; i < 4; i++) tick();
        nvec++; if (bus0.OUT !== 4'b0000) begin nerr++; $display("FAIL t2_neg_e4: got %b want 0000", bus0.OUT); end
        tick();
        nvec++; if (bus0.OUT !== 4'b0010) begin nerr++; $display("FAIL t2_neg_out: got %b want 0010", bus0.OUT); end
        nvec++; if (bus0.OUT_SIGN !== 4'b0010) begin nerr++; $display("FAIL t2_neg_osgn: got %b want 0010", bus0.OUT_SIGN); end
        for (int i = 0; i < 5; i++) tick();
        nvec++; if (bus0.OUT !== 4'b0010) begin nerr++; $display("FAIL t2_neg_hold: got %b want 0010", bus0.OUT); end
        bus0.IN = 4'b0000; bus0.SIGN = 4'b0000;
        tick(); tick();
        nvec++; if (bus0.OUT !== 4'b0000) begin nerr++; $display("FAIL t2_drop: got %b want 0000", bus0.OUT); end
    endtask

    task automatic test_accum();
        bus0.MODE = 1'b1; bus0.IN = '0; bus0.SIGN = '0;
        tick();
        nvec++; if (bus0.OUT !== 4'b0000) begin nerr++; $display("FAIL t3_switch_out: got %b want 0000", bus0.OUT); end
        bus0.IN = 4'b0100; bus0.SIGN = 4'b0000;
        for (int i = 0; i < 40; i++) tick();
        bus0.IN = 4'b0000; tick();
        nvec++; if (bus0.SAT !== 4'b0100) begin nerr++; $display("FAIL t3_pos_sat: got %b want 0100", bus0.SAT); end
        nvec++; if (bus0.OUT !== 4'b0100) begin nerr++; $display("FAIL t3_pos_out: got %b want 0100", bus0.OUT); end
        nvec++; if (bus0.OUT_SIGN !== 4'b0000) begin nerr++; $display("FAIL t3_pos_osgn: got %b want 0000", bus0.OUT_SIGN); end
        bus0.IN = 4'b0100; bus0.SIGN = 4'b0100;
        for (int i = 0; i < 10; i++) tick();
        bus0.IN = 4'b0000; tick();
        nvec++; if (bus0.SAT !== 4'b0000) begin nerr++; $display("FAIL t3_acc21_sat: got %b want 0000", bus0.SAT); end
        nvec++; if (bus0.OUT !== 4'b0100) begin nerr++; $display("FAIL t3_acc21_out: got %b want 0100", bus0.OUT); end
        bus0.IN = 4'b0100;
        for (int i = 0; i < 30; i++) tick();
        bus0.IN = 4'b0000; tick();
        nvec++; if (bus0.OUT !== 4'b0100) begin nerr++; $display("FAIL t3_m9_out: got %b want 0100", bus0.OUT); end
        nvec++; if (bus0.OUT_SIGN !== 4'b0100) begin nerr++; $display("FAIL t3_m9_osgn: got %b want 0100", bus0.OUT_SIGN); end
        nvec++; if (bus0.SAT !== 4'b0000) begin nerr++; $display("FAIL t3_m9_sat: got %b want 0000", bus0.SAT); end
        // threshold boundary: |ACC| = 8 is on, 7 is off
        bus0.IN = 4'b0100; bus0.SIGN = 4'b0000; tick();
        bus0.IN = 4'b0000; tick();
        nvec++; if (bus0.OUT !== 4'b0100) begin nerr++; $display("FAIL t3_m8_out: got %b want 0100", bus0.OUT); end
        bus0.IN = 4'b0100; tick();
        bus0.IN = 4'b0000; tick();
        nvec++; if (bus0.OUT !== 4'b0000) begin nerr++; $display("FAIL t3_m7_out: got %b want 0000", bus0.OUT); end
        nvec++; if (bus0.OUT_SIGN !== 4'b0100) begin nerr++; $display("FAIL t3_m7_osgn: got %b want 0100", bus0.OUT_SIGN); end
        bus0.IN = 4'b0100; bus0.SIGN = 4'b0100;
        for (int i = 0; i < 40; i++) tick();
        bus0.IN = 4'b0000; bus0.SIGN = 4'b0000; tick();
        nvec++; if (bus0.SAT !== 4'b0100) begin nerr++; $display("FAIL t3_neg_sat: got %b want 0100", bus0.SAT); end
        nvec++; if (bus0.OUT_SIGN !== 4'b0100) begin nerr++; $display("FAIL t3_neg_osgn: got %b want 0100", bus0.OUT_SIGN); end
    endtask

    task automatic test_leak();
        bus1.IN = 4'b0001; bus1.SIGN = 4'b0000;
        INIT1 = 1'b0;
        for (int e = 1; e <= 5; e++) tick();
        bus1.IN = 4'b0000;
        for (int e = 6; e <= 65; e++) begin
            bus1.IN   = (e >= 61 && e <= 63) ? 4'b0001 : 4'b0000;
            bus1.SIGN = (e >= 61 && e <= 63) ? 4'b0001 : 4'b0000;
            tick();
            if (e == 6) begin
                nvec++; if (bus1.OUT !== 4'b0001) begin nerr++; $display("FAIL t4_e6_out: got %b want 0001", bus1.OUT); end
            end
            if (e == 24) begin
                nvec++; if (bus1.OUT !== 4'b0001) begin nerr++; $display("FAIL t4_e24_out: got %b want 0001", bus1.OUT); end
            end
            if (e == 25) begin
                nvec++; if (bus1.OUT !== 4'b0000) begin nerr++; $display("FAIL t4_e25_out: got %b want 0000", bus1.OUT); end
            end
            if (e == 60) begin
                nvec++; if (bus1.OUT_SIGN !== 4'b0000) begin nerr++; $display("FAIL t4_e60_osgn: got %b want 0000", bus1.OUT_SIGN); end
            end
            if (e == 64) begin
                nvec++; if (bus1.OUT !== 4'b0001) begin nerr++; $display("FAIL t4_e64_out: got %b want 0001", bus1.OUT); end
                nvec++; if (bus1.OUT_SIGN !== 4'b0001) begin nerr++; $display("FAIL t4_e64_osgn: got %b want 0001", bus1.OUT_SIGN); end
            end
            if (e == 65) begin
                nvec++; if (bus1.OUT !== 4'b0000) begin nerr++; $display("FAIL t4_e65_out: got %b want 0000", bus1.OUT); end
                nvec++; if (bus1.OUT_SIGN !== 4'b0001) begin nerr++; $display("FAIL t4_e65_osgn: got %b want 0001", bus1.OUT_SIGN); end
            end
        end
    endtask

    task automatic test_enable();
        bus0.EN = 1'b0; bus0.IN = 4'b1111; bus0.SIGN = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            tick();
            nvec++; if (bus0.OUT !== 4'b0100) begin nerr++; $display("FAIL t5_frz_out %0d: got %b want 0100", i, bus0.OUT); end
            nvec++; if (bus0.SAT !== 4'b0100) begin nerr++; $display("FAIL t5_frz_sat %0d: got %b want 0100", i, bus0.SAT); end
        end
        bus0.MODE = 1'b0; bus0.IN = 4'b0000;
        tick();
        nvec++; if (bus0.SAT !== 4'b0100) begin nerr++; $display("FAIL t5_mode_en0: got %b want 0100", bus0.SAT); end
        bus0.EN = 1'b1;
        tick();
        nvec++; if (bus0.SAT !== 4'b0000) begin nerr++; $display("FAIL t5_mode_clr_sat: got %b want 0000", bus0.SAT); end
        nvec++; if (bus0.OUT_SIGN !== 4'b0000) begin nerr++; $display("FAIL t5_mode_clr_osgn: got %b want 0000", bus0.OUT_SIGN); end
        bus0.IN = 4'b0001;
        for (int i = 0; i < 5; i++) tick();
        nvec++; if (bus0.OUT !== 4'b0001) begin nerr++; $display("FAIL t5_run_out: got %b want 0001", bus0.OUT); end
        bus0.EN = 1'b0; INIT0 = 1'b1;
        tick();
        INIT0 = 1'b0; bus0.EN = 1'b1; bus0.IN = 4'b0000;
        nvec++; if (bus0.OUT !== 4'b0000) begin nerr++; $display("FAIL t5_init_en0: got %b want 0000", bus0.OUT); end
    endtask

    task automatic test_mode_switch();
        bus0.MODE = 1'b1; INIT0 = 1'b1;
        tick();
        INIT0 = 1'b0;
        bus0.IN = 4'b1000; bus0.SIGN = 4'b0000;
        for (int i = 0; i < 20; i++) tick();
        bus0.IN = 4'b0000; tick();
        nvec++; if (bus0.OUT !== 4'b1000) begin nerr++; $display("FAIL t6_acc20_out: got %b want 1000", bus0.OUT); end
        nvec++; if (bus0.SAT !== 4'b0000) begin nerr++; $display("FAIL t6_acc20_sat: got %b want 0000", bus0.SAT); end
        bus0.MODE = 1'b0;
        tick();
        nvec++; if (bus0.OUT !== 4'b0000) begin nerr++; $display("FAIL t6_clr_out: got %b want 0000", bus0.OUT); end
        bus0.IN = 4'b1000;
        for (int i = 0; i < 4; i++) tick();
        nvec++; if (bus0.OUT !== 4'b0000) begin nerr++; $display("FAIL t6_run_e4: got %b want 0000", bus0.OUT); end
        tick();
        nvec++; if (bus0.OUT !== 4'b1000) begin nerr++; $display("FAIL t6_run_e5: got %b want 1000", bus0.OUT); end
    endtask

    task automatic test_channels();
        bus0.MODE = 1'b0; bus0.IN = '0; bus0.SIGN = '0; INIT0 = 1'b1;
        tick();
        INIT0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus0.IN   = 4'b0111;
            bus0.SIGN = (i % 2 == 0) ? 4'b0110 : 4'b0010;
            tick();
        end
        nvec++; if (bus0.OUT !== 4'b0011) begin nerr++; $display("FAIL mc_out: got %b want 0011", bus0.OUT); end
        nvec++; if (bus0.OUT_SIGN !== 4'b0010) begin nerr++; $display("FAIL mc_osgn: got %b want 0010", bus0.OUT_SIGN); end
        nvec++; if (bus0.SAT !== 4'b0000) begin nerr++; $display("FAIL mc_sat: got %b want 0000", bus0.SAT); end
    endtask

    initial begin
        test_reset();
        test_run_pos();
        test_run_alt();
        test_accum();
        test_leak();
        test_enable();
        test_mode_switch();
        test_channels();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
